// File: rtl/bmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bmp_pkg
// Description : Shared constants, state encoding and row-padding helper for
//               the BMP stream writer.
// Revision    : 1.0 - initial release
// ============================================================================
package bmp_pkg;

    localparam int BMP_HDR_BYTES = 54;
    localparam int DIB_SIZE      = 40;
    localparam int BPP           = 24;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_HEADER  = 3'd2,
        ST_PIXELS  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Zero bytes needed to round a 24-bit row up to a 4-byte boundary.
    function automatic int row_pad(input int width);
        return (4 - (width * 3) % 4) % 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bmp_stream_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : bmp_stream_writer_if
// Description : Byte-serial valid/ready stream carrying the BMP file.
// Revision    : 1.0 - initial release
// ============================================================================
interface bmp_stream_writer_if;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface
`default_nettype wire

// File: rtl/bmp_header_rom.sv
`default_nettype none
// ============================================================================
// Module      : bmp_header_rom
// Description : Combinational 54-byte BMP/DIB header lookup for a fixed size.
// Revision    : 1.0 - initial release
// ============================================================================
module bmp_header_rom #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input  wire logic [5:0] i_index,
    output logic      [7:0] o_byte
);
    import bmp_pkg::*;

    localparam int          ROW_BYTES   = WIDTH * 3 + row_pad(WIDTH);
    localparam logic [31:0] c_IMG_SIZE  = 32'(ROW_BYTES * HEIGHT);
    localparam logic [31:0] c_FILE_SIZE = 32'(BMP_HDR_BYTES + ROW_BYTES * HEIGHT);
    localparam logic [31:0] c_WIDTH     = 32'(WIDTH);
    localparam logic [31:0] c_HEIGHT    = 32'(HEIGHT);

    // All multi-byte fields are little-endian; unlisted offsets are zero.
    always_comb begin
        o_byte = 8'h00;
        case (i_index)
            6'd0:  o_byte = 8'h42;
            6'd1:  o_byte = 8'h4D;
            6'd2:  o_byte = c_FILE_SIZE[7:0];
            6'd3:  o_byte = c_FILE_SIZE[15:8];
            6'd4:  o_byte = c_FILE_SIZE[23:16];
            6'd5:  o_byte = c_FILE_SIZE[31:24];
            6'd10: o_byte = 8'(BMP_HDR_BYTES);
            6'd14: o_byte = 8'(DIB_SIZE);
            6'd18: o_byte = c_WIDTH[7:0];
            6'd19: o_byte = c_WIDTH[15:8];
            6'd20: o_byte = c_WIDTH[23:16];
            6'd21: o_byte = c_WIDTH[31:24];
            6'd22: o_byte = c_HEIGHT[7:0];
            6'd23: o_byte = c_HEIGHT[15:8];
            6'd24: o_byte = c_HEIGHT[23:16];
            6'd25: o_byte = c_HEIGHT[31:24];
            6'd26: o_byte = 8'h01;
            6'd28: o_byte = 8'(BPP);
            6'd34: o_byte = c_IMG_SIZE[7:0];
            6'd35: o_byte = c_IMG_SIZE[15:8];
            6'd36: o_byte = c_IMG_SIZE[23:16];
            6'd37: o_byte = c_IMG_SIZE[31:24];
            default: o_byte = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bmp_stream_writer.sv
`default_nettype none
// ============================================================================
// Module      : bmp_stream_writer
// Description : Captures one two-pixel-per-clock RGB888 frame and replays it
//               as a byte-serial 24-bit bottom-up BMP file.
// Revision    : 1.0 - initial release
// ============================================================================
module bmp_stream_writer #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input  wire logic       HCLK,
    input  wire logic       HRESET,
    input  wire logic       VSYNC_IN,
    input  wire logic       HSYNC_IN,
    input  wire logic [7:0] DATA_R0,
    input  wire logic [7:0] DATA_G0,
    input  wire logic [7:0] DATA_B0,
    input  wire logic [7:0] DATA_R1,
    input  wire logic [7:0] DATA_G1,
    input  wire logic [7:0] DATA_B1,
    bmp_stream_writer_if.master bus,
    output logic            capture_done,
    output logic            overrun
);
    import bmp_pkg::*;

    localparam int PAD       = row_pad(WIDTH);
    localparam int ROW_BYTES = WIDTH * 3 + PAD;
    localparam int PPR       = WIDTH / 2;
    localparam int NPAIRS    = PPR * HEIGHT;
    localparam int ADDR_W    = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam int ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int PAIR_W    = (PPR > 1) ? $clog2(PPR) : 1;
    localparam int BYTE_W    = $clog2(ROW_BYTES + 1);

    localparam logic [ADDR_W-1:0] c_LAST_PAIR     = ADDR_W'(NPAIRS - 1);
    localparam logic [ADDR_W-1:0] c_PPR           = ADDR_W'(PPR);
    localparam logic [ROW_W-1:0]  c_TOP_ROW       = ROW_W'(HEIGHT - 1);
    localparam logic [PAIR_W-1:0] c_ROW_LAST_PAIR = PAIR_W'(PPR - 1);
    localparam logic [BYTE_W-1:0] c_ROW_LAST_BYTE = BYTE_W'(ROW_BYTES - 1);
    localparam logic [BYTE_W-1:0] c_PIX_BYTES     = BYTE_W'(WIDTH * 3);
    localparam logic [5:0]        c_HDR_LAST      = 6'(BMP_HDR_BYTES - 1);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_pair_cnt, w_pair_cnt_nxt;
    logic                w_wr_en, w_cap_final;
    logic [47:0]         r_mem [NPAIRS];
    logic [47:0]         r_rd_data;
    logic [ADDR_W-1:0]   w_rd_addr;

    logic [5:0]          r_hdr_idx, w_hdr_nxt;
    logic [ROW_W-1:0]    r_row, w_row_nxt;
    logic [PAIR_W-1:0]   r_pair, w_pair_nxt;
    logic [2:0]          r_sub, w_sub_nxt;
    logic [BYTE_W-1:0]   r_byte, w_byte_nxt;
    logic                r_gen_done, w_gen_done_nxt;

    logic [7:0]          r_out_data;
    logic                r_out_valid, r_out_last;
    logic                w_take, w_load, w_gen_last;
    logic [7:0]          w_gen_byte, w_rom_byte;
    logic                r_capture_done, r_overrun;

    bmp_header_rom #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_hdr_rom (
        .i_index (r_hdr_idx),
        .o_byte  (w_rom_byte)
    );

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pair_cnt_nxt = r_pair_cnt;
        w_wr_en        = 1'b0;
        w_cap_final    = 1'b0;
        w_hdr_nxt      = r_hdr_idx;
        w_row_nxt      = r_row;
        w_pair_nxt     = r_pair;
        w_sub_nxt      = r_sub;
        w_byte_nxt     = r_byte;
        w_gen_done_nxt = r_gen_done;
        w_take         = !r_out_valid || bus.out_ready;
        w_load         = 1'b0;
        w_gen_byte     = 8'h00;
        w_gen_last     = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (VSYNC_IN) begin
                    w_state_nxt    = ST_CAPTURE;
                    w_pair_cnt_nxt = '0;
                end
            end
            ST_CAPTURE: begin
                if (VSYNC_IN && (r_pair_cnt != '0)) begin
                    w_pair_cnt_nxt = '0;
                end else if (HSYNC_IN) begin
                    w_wr_en = 1'b1;
                    if (r_pair_cnt == c_LAST_PAIR) begin
                        w_cap_final    = 1'b1;
                        w_state_nxt    = ST_HEADER;
                        w_pair_cnt_nxt = '0;
                    end else begin
                        w_pair_cnt_nxt = r_pair_cnt + 1'b1;
                    end
                end
            end
            ST_HEADER: begin
                w_gen_byte = w_rom_byte;
                w_load     = w_take;
                if (w_load) begin
                    if (r_hdr_idx == c_HDR_LAST) w_state_nxt = ST_PIXELS;
                    else                         w_hdr_nxt   = r_hdr_idx + 1'b1;
                end
            end
            ST_PIXELS: begin
                w_gen_byte = (r_byte < c_PIX_BYTES) ? r_rd_data[{r_sub, 3'b000} +: 8] : 8'h00;
                w_gen_last = (r_row == '0) && (r_byte == c_ROW_LAST_BYTE);
                w_load     = w_take && !r_gen_done;
                if (w_load) begin
                    if (r_byte == c_ROW_LAST_BYTE) begin
                        w_byte_nxt = '0;
                        w_sub_nxt  = '0;
                        w_pair_nxt = '0;
                        if (r_row == '0) w_gen_done_nxt = 1'b1;
                        else             w_row_nxt      = r_row - 1'b1;
                    end else begin
                        w_byte_nxt = r_byte + 1'b1;
                        if (r_sub == 3'd5) begin
                            w_sub_nxt = '0;
                            if (r_pair != c_ROW_LAST_PAIR) w_pair_nxt = r_pair + 1'b1;
                        end else begin
                            w_sub_nxt = r_sub + 1'b1;
                        end
                    end
                end
                if (r_out_valid && bus.out_ready && r_out_last) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Outside replay the cursors sit at the first header byte and the top
        // stored row, so the RAM already presents the first pixel word.
        if ((w_state_nxt != ST_HEADER) && (w_state_nxt != ST_PIXELS)) begin
            w_hdr_nxt      = '0;
            w_row_nxt      = c_TOP_ROW;
            w_pair_nxt     = '0;
            w_sub_nxt      = '0;
            w_byte_nxt     = '0;
            w_gen_done_nxt = 1'b0;
        end
    end

    // Read address follows the next cursor, hiding the one-cycle RAM latency.
    assign w_rd_addr = ADDR_W'(w_row_nxt) * c_PPR + ADDR_W'(w_pair_nxt);

    always_ff @(posedge HCLK) begin
        if (w_wr_en) r_mem[r_pair_cnt] <= {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0};
        r_rd_data <= r_mem[w_rd_addr];
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_pair_cnt     <= '0;
            r_hdr_idx      <= '0;
            r_row          <= '0;
            r_pair         <= '0;
            r_sub          <= '0;
            r_byte         <= '0;
            r_gen_done     <= 1'b0;
            r_out_data     <= 8'h00;
            r_out_valid    <= 1'b0;
            r_out_last     <= 1'b0;
            r_capture_done <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_pair_cnt     <= w_pair_cnt_nxt;
            r_hdr_idx      <= w_hdr_nxt;
            r_row          <= w_row_nxt;
            r_pair         <= w_pair_nxt;
            r_sub          <= w_sub_nxt;
            r_byte         <= w_byte_nxt;
            r_gen_done     <= w_gen_done_nxt;
            r_capture_done <= w_cap_final;
            if (HSYNC_IN && (r_state != ST_CAPTURE)) r_overrun <= 1'b1;
            if (w_take) begin
                r_out_valid <= w_load;
                r_out_data  <= w_load ? w_gen_byte : 8'h00;
                r_out_last  <= w_load && w_gen_last;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign capture_done  = r_capture_done;
    assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_bmp_stream_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bmp_stream_writer
// Description : Scoreboard bench for the BMP stream writer (4x2 and 2x2 frames).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bmp_stream_writer;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b0;
    logic       a_vsync = 1'b0, a_hsync = 1'b0, b_vsync = 1'b0, b_hsync = 1'b0;
    logic [7:0] d_r0 = '0, d_g0 = '0, d_b0 = '0, d_r1 = '0, d_g1 = '0, d_b1 = '0;
    logic       a_done, a_ovr, b_done, b_ovr;
    logic [5:0] rom_idx = '0;
    logic [7:0] rom_byte;

    bmp_stream_writer_if a_bus ();
    bmp_stream_writer_if b_bus ();

    always #5 HCLK = ~HCLK;

    bmp_stream_writer #(.WIDTH(4), .HEIGHT(2)) u_dut_a (
        .HCLK(HCLK), .HRESET(HRESET), .VSYNC_IN(a_vsync), .HSYNC_IN(a_hsync),
        .DATA_R0(d_r0), .DATA_G0(d_g0), .DATA_B0(d_b0),
        .DATA_R1(d_r1), .DATA_G1(d_g1), .DATA_B1(d_b1),
        .bus(a_bus), .capture_done(a_done), .overrun(a_ovr));

    bmp_stream_writer #(.WIDTH(2), .HEIGHT(2)) u_dut_b (
        .HCLK(HCLK), .HRESET(HRESET), .VSYNC_IN(b_vsync), .HSYNC_IN(b_hsync),
        .DATA_R0(d_r0), .DATA_G0(d_g0), .DATA_B0(d_b0),
        .DATA_R1(d_r1), .DATA_G1(d_g1), .DATA_B1(d_b1),
        .bus(b_bus), .capture_done(b_done), .overrun(b_ovr));

    bmp_header_rom #(.WIDTH(768), .HEIGHT(512)) u_rom_big (.i_index(rom_idx), .o_byte(rom_byte));

    logic [8:0] q_a[$], q_b[$], q_build[$];
    logic [7:0] a_log[$], b_log[$];
    int  n_vec = 0, n_err = 0;
    int  a_xfer = 0, b_xfer = 0, a_done_cnt = 0;
    bit  rand_ready = 1'b0;
    bit  a_prev_stall = 1'b0;
    logic [7:0] a_prev_data;
    logic       a_prev_last;

    function automatic logic [47:0] mkpair(input int v);
        return {8'(v + 3), 8'(v + 4), 8'(v + 5), 8'(v), 8'(v + 1), 8'(v + 2)};
    endfunction

    task automatic put_le(input int value, input int nbytes);
        for (int i = 0; i < nbytes; i++) q_build.push_back({1'b0, 8'(value >> (8 * i))});
    endtask

    // Reference BMP image of a frame whose pair k holds ramp base+6k.
    task automatic build_file(input int w, input int h, input int base);
        int pad, img;
        logic [47:0] pr;
        logic [23:0] px;
        logic [8:0]  tail;
        pad = (4 - (w * 3) % 4) % 4;
        img = (w * 3 + pad) * h;
        q_build.delete();
        put_le(16'h4D42, 2); put_le(54 + img, 4); put_le(0, 4); put_le(54, 4);
        put_le(40, 4); put_le(w, 4); put_le(h, 4); put_le(1, 2); put_le(24, 2);
        put_le(0, 4); put_le(img, 4);
        for (int i = 0; i < 16; i++) put_le(0, 1);
        for (int r = h - 1; r >= 0; r--) begin
            for (int c = 0; c < w; c++) begin
                pr = mkpair(base + 6 * (r * (w / 2) + c / 2));
                px = (c % 2 == 1) ? pr[47:24] : pr[23:0];
                put_le(int'(px[7:0]), 1); put_le(int'(px[15:8]), 1); put_le(int'(px[23:16]), 1);
            end
            for (int p = 0; p < pad; p++) put_le(0, 1);
        end
        tail = q_build.pop_back();
        q_build.push_back({1'b1, tail[7:0]});
    endtask

    task automatic start_frame(input bit to_b);
        @(posedge HCLK); #1;
        if (to_b) b_vsync = 1'b1; else a_vsync = 1'b1;
        @(posedge HCLK); #1;
        a_vsync = 1'b0; b_vsync = 1'b0;
    endtask

    task automatic send_pairs(input bit to_b, input int base, input int count);
        for (int k = 0; k < count; k++) begin
            @(posedge HCLK); #1;
            {d_r1, d_g1, d_b1, d_r0, d_g0, d_b0} = mkpair(base + 6 * k);
            if (to_b) b_hsync = 1'b1; else a_hsync = 1'b1;
        end
        @(posedge HCLK); #1;
        a_hsync = 1'b0; b_hsync = 1'b0;
    endtask

    task automatic wait_drain(input bit to_b, input string name);
        int budget;
        budget = 3000;
        while (budget > 0 && (to_b ? (q_b.size() != 0 || b_bus.out_valid !== 1'b0)
                                   : (q_a.size() != 0 || a_bus.out_valid !== 1'b0))) begin
            @(posedge HCLK); budget--;
        end
        n_vec++;
        if (budget == 0) begin
            n_err++;
            $display("FAIL %s_drain: timed out with %0d bytes outstanding, required 0", name,
                     to_b ? q_b.size() : q_a.size());
        end
        #1;
    endtask

    task automatic wait_xfer_a(input int n);
        int budget;
        budget = 2000;
        while (budget > 0 && a_xfer < n) begin @(posedge HCLK); budget--; end
        n_vec++;
        if (budget == 0) begin
            n_err++;
            $display("FAIL wait_xfer: got %0d bytes, required %0d", a_xfer, n);
        end
        #1;
    endtask

    task automatic chk(input string name, input int actual, input int required);
        n_vec++;
        if (actual !== required) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    initial forever begin
        @(posedge HCLK); #1;
        a_bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    initial b_bus.out_ready = 1'b1;

    always @(negedge HCLK) begin
        logic [8:0] e;
        if (a_prev_stall && HRESET) begin
            n_vec++;
            if (a_bus.out_valid !== 1'b1 || a_bus.out_data !== a_prev_data || a_bus.out_last !== a_prev_last) begin
                n_err++;
                $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                         a_bus.out_valid, a_bus.out_data, a_bus.out_last, a_prev_data, a_prev_last);
            end
        end
        a_prev_stall = (a_bus.out_valid === 1'b1) && (a_bus.out_ready !== 1'b1);
        a_prev_data  = a_bus.out_data;
        a_prev_last  = a_bus.out_last;
        if (a_done === 1'b1) a_done_cnt++;
        if (a_bus.out_valid === 1'b1 && a_bus.out_ready === 1'b1) begin
            n_vec++;
            a_log.push_back(a_bus.out_data);
            if (q_a.size() == 0) begin
                n_err++;
                $display("FAIL a_byte%0d: unexpected byte %h last=%b, required none", a_xfer, a_bus.out_data, a_bus.out_last);
            end else begin
                e = q_a.pop_front();
                if ({a_bus.out_last, a_bus.out_data} !== e) begin
                    n_err++;
                    $display("FAIL a_byte%0d: got last=%b data=%h, required last=%b data=%h",
                             a_xfer, a_bus.out_last, a_bus.out_data, e[8], e[7:0]);
                end
            end
            a_xfer++;
        end
        if (b_bus.out_valid === 1'b1 && b_bus.out_ready === 1'b1) begin
            n_vec++;
            b_log.push_back(b_bus.out_data);
            if (q_b.size() == 0) begin
                n_err++;
                $display("FAIL b_byte%0d: unexpected byte %h, required none", b_xfer, b_bus.out_data);
            end else begin
                e = q_b.pop_front();
                if ({b_bus.out_last, b_bus.out_data} !== e) begin
                    n_err++;
                    $display("FAIL b_byte%0d: got last=%b data=%h, required last=%b data=%h",
                             b_xfer, b_bus.out_last, b_bus.out_data, e[8], e[7:0]);
                end
            end
            b_xfer++;
        end
    end

    task automatic clear_a();
        a_xfer = 0; a_done_cnt = 0; a_log.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge HCLK);
        #1;
        chk("reset_a_valid", int'(a_bus.out_valid), 0);
        chk("reset_a_data",  int'(a_bus.out_data), 0);
        chk("reset_a_last",  int'(a_bus.out_last), 0);
        chk("reset_a_done",  int'(a_done), 0);
        chk("reset_a_ovr",   int'(a_ovr), 0);
        chk("reset_b_valid", int'(b_bus.out_valid), 0);
        chk("reset_b_ovr",   int'(b_ovr), 0);
        HRESET = 1'b1;
    endtask

    task automatic test_frame_basic();
        clear_a();
        build_file(4, 2, 1);
        q_a = q_build;
        start_frame(1'b0);
        send_pairs(1'b0, 1, 4);
        chk("capture_done_pulse", int'(a_done), 1);
        @(posedge HCLK); #1;
        chk("capture_done_clear", int'(a_done), 0);
        wait_drain(1'b0, "basic");
        chk("basic_total_bytes", a_xfer, 78);
        chk("basic_done_count", a_done_cnt, 1);
        chk("basic_byte54", int'(a_log[54]), 15);
        chk("basic_byte66", int'(a_log[66]), 3);
        chk("basic_byte77", int'(a_log[77]), 10);
        chk("basic_no_overrun", int'(a_ovr), 0);
    endtask

    task automatic test_header_big();
        int idx[12] = '{2, 3, 4, 5, 18, 19, 20, 21, 22, 23, 34, 36};
        int exp[12] = '{8'h36, 8'h00, 8'h12, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h12};
        for (int i = 0; i < 12; i++) begin
            rom_idx = 6'(idx[i]);
            #1;
            chk($sformatf("hdr768_idx%0d", idx[i]), int'(rom_byte), exp[i]);
        end
    endtask

    task automatic test_row_padding();
        b_xfer = 0; b_log.delete();
        build_file(2, 2, 1);
        q_b = q_build;
        start_frame(1'b1);
        send_pairs(1'b1, 1, 2);
        wait_drain(1'b1, "pad");
        chk("pad_total_bytes", b_xfer, 70);
        chk("pad_filesize", int'(b_log[2]), 70);
        chk("pad_imagesize", int'(b_log[34]), 16);
        chk("pad_first_pixel", int'(b_log[54]), 9);
        chk("pad_byte60", int'(b_log[60]), 0);
        chk("pad_byte61", int'(b_log[61]), 0);
    endtask

    task automatic test_backpressure();
        clear_a();
        build_file(4, 2, 1);
        q_a = q_build;
        rand_ready = 1'b1;
        start_frame(1'b0);
        send_pairs(1'b0, 1, 4);
        wait_drain(1'b0, "backpressure");
        rand_ready = 1'b0;
        chk("bp_total_bytes", a_xfer, 78);
    endtask

    task automatic test_vsync_restart();
        clear_a();
        build_file(4, 2, 101);
        q_a = q_build;
        start_frame(1'b0);
        send_pairs(1'b0, 200, 3);
        start_frame(1'b0);
        chk("restart_no_done", a_done_cnt, 0);
        send_pairs(1'b0, 101, 4);
        chk("restart_done_pulse", int'(a_done), 1);
        wait_drain(1'b0, "restart");
        chk("restart_done_count", a_done_cnt, 1);
        chk("restart_total_bytes", a_xfer, 78);
    endtask

    task automatic test_overrun();
        clear_a();
        build_file(4, 2, 1);
        q_a = q_build;
        start_frame(1'b0);
        send_pairs(1'b0, 1, 4);
        wait_xfer_a(60);
        @(posedge HCLK); #1;
        {d_r1, d_g1, d_b1, d_r0, d_g0, d_b0} = {6{8'hEE}};
        a_hsync = 1'b1;
        @(posedge HCLK); #1;
        a_hsync = 1'b0;
        chk("overrun_set", int'(a_ovr), 1);
        wait_drain(1'b0, "overrun");
        chk("overrun_sticky", int'(a_ovr), 1);
        chk("overrun_total_bytes", a_xfer, 78);
    endtask

    task automatic test_reset_mid();
        clear_a();
        build_file(4, 2, 1);
        q_a = q_build;
        start_frame(1'b0);
        send_pairs(1'b0, 1, 4);
        wait_xfer_a(58);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("midreset_valid", int'(a_bus.out_valid), 0);
        chk("midreset_ovr", int'(a_ovr), 0);
        chk("midreset_last", int'(a_bus.out_last), 0);
        q_a.delete();
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        clear_a();
        build_file(4, 2, 1);
        q_a = q_build;
        start_frame(1'b0);
        send_pairs(1'b0, 1, 4);
        wait_drain(1'b0, "post_reset");
        chk("post_reset_total_bytes", a_xfer, 78);
    endtask

    initial begin
        test_reset();
        test_frame_basic();
        test_header_big();
        test_row_padding();
        test_backpressure();
        test_vsync_restart();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
